// File: rtl/qerv_rf_pkg.sv
// Shared constants, types and parameter helpers for the qerv register-file RAM interface.
// No logic here; latency and backpressure are properties of the modules that import it.
package qerv_rf_pkg;

  localparam int MSCRATCH = 32;
  localparam int MTVEC    = 33;
  localparam int MEPC     = 34;
  localparam int MTVAL    = 35;

  typedef enum logic [1:0] {
    R_IDLE,
    R_T1,
    R_T2,
    R_STREAM
  } rstate_t;

  function automatic int rf_rw(input int csr_regs);
    return (csr_regs > 0) ? 6 : 5;
  endfunction

  function automatic int rf_aw(input int width, input int csr_regs);
    return $clog2((32 + csr_regs) * (32 / width));
  endfunction

endpackage

// File: rtl/qerv_rf_ram.sv
// 1R1W synchronous RAM, depth x width, one cycle read latency, old data on read-during-write.
// No backpressure; rdata holds its value on cycles without ren.
module qerv_rf_ram #(
  parameter int width = 8,
  parameter int depth = 144,
  localparam int aw = $clog2(depth)
) (
  input  logic             clk,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             wen,
  input  logic [aw-1:0]    raddr,
  input  logic             ren,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/qerv_rf_ram_if.sv
// Serial RF ports to 1R1W RAM bridge: writes commit 1/2 cycles after a word's last beat,
// reads stream 3 cycles after i_rreq; no backpressure, the core drives beats at its own pace.
module qerv_rf_ram_if
  import qerv_rf_pkg::*;
#(
  parameter int width    = 8,
  parameter int W        = 1,
  parameter int csr_regs = 4,
  localparam int rw = rf_rw(csr_regs),
  localparam int aw = rf_aw(width, csr_regs)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_wreq,
  input  logic             i_rreq,
  output logic             o_ready,
  input  logic [rw-1:0]    i_wreg0,
  input  logic [rw-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [W-1:0]     i_wdata0,
  input  logic [W-1:0]     i_wdata1,
  input  logic [rw-1:0]    i_rreg0,
  input  logic [rw-1:0]    i_rreg1,
  output logic [W-1:0]     o_rdata0,
  output logic [W-1:0]     o_rdata1,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  localparam int n     = width / W;
  localparam int wpr   = 32 / width;
  localparam int beats = 32 / W;
  localparam int cw    = $clog2(beats);

  function automatic logic [aw-1:0] ram_addr(input logic [rw-1:0] r, input int word);
    return aw'(int'(r) * wpr + word);
  endfunction

  // ---------------- write path ----------------
  logic [cw-1:0]    wcnt;
  logic [width-1:0] wbuf0, wbuf1;
  logic             wflag0, wflag1;
  logic             pend1;
  logic [aw-1:0]    c_addr1;
  logic [width-1:0] c_data1;

  logic             wactive;
  logic [width-1:0] wbuf0_n, wbuf1_n;
  logic             wflag0_n, wflag1_n;
  int               wbeat, wword;

  always_comb begin
    wactive  = i_wen0 | i_wen1;
    wbuf0_n  = {i_wdata0, wbuf0[width-1:W]};
    wbuf1_n  = {i_wdata1, wbuf1[width-1:W]};
    wflag0_n = wflag0 | i_wen0;
    wflag1_n = wflag1 | i_wen1;
    wbeat    = int'(wcnt) % n;
    wword    = int'(wcnt) / n;
  end

  // Port 0 goes straight to the RAM port; port 1 waits one cycle in the commit stage.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wcnt    <= '0;
      wbuf0   <= '0;
      wbuf1   <= '0;
      wflag0  <= 1'b0;
      wflag1  <= 1'b0;
      pend1   <= 1'b0;
      c_addr1 <= '0;
      c_data1 <= '0;
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_wen <= 1'b0;
      if (pend1) begin
        o_wen   <= 1'b1;
        o_waddr <= c_addr1;
        o_wdata <= c_data1;
        pend1   <= 1'b0;
      end
      if (i_wreq) begin
        wcnt   <= '0;
        wflag0 <= 1'b0;
        wflag1 <= 1'b0;
      end else if (wactive) begin
        wcnt  <= wcnt + 1'b1;
        wbuf0 <= wbuf0_n;
        wbuf1 <= wbuf1_n;
        if (wbeat == n - 1) begin
          wflag0  <= 1'b0;
          wflag1  <= 1'b0;
          o_wen   <= wflag0_n;
          o_waddr <= ram_addr(i_wreg0, wword);
          o_wdata <= wbuf0_n;
          pend1   <= wflag1_n;
          c_addr1 <= ram_addr(i_wreg1, wword);
          c_data1 <= wbuf1_n;
        end else begin
          wflag0 <= wflag0_n;
          wflag1 <= wflag1_n;
        end
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t          rstate;
  logic [rw-1:0]    rreg0_q, rreg1_q;
  logic [cw-1:0]    bcnt;
  logic [width-1:0] stage0, sh0, sh1;
  logic             reload;

  logic [width-1:0] src0, src1;
  int               rbeat, rword;

  always_comb begin
    rbeat = int'(bcnt) % n;
    rword = int'(bcnt) / n;
    src0  = reload ? stage0 : sh0;
    src1  = reload ? i_rdata : sh1;
    o_rdata0 = (rstate == R_STREAM && rreg0_q != '0) ? src0[W-1:0] : '0;
    o_rdata1 = (rstate == R_STREAM && rreg1_q != '0) ? src1[W-1:0] : '0;
  end

  // Issue address is combinational so the first read goes out in the i_rreq cycle itself,
  // and the rreg1 prefetch lands exactly on beat 0 of the next word.
  always_comb begin
    o_ren   = 1'b0;
    o_raddr = '0;
    if (!i_rst) begin
      if (i_rreq) begin
        o_ren   = 1'b1;
        o_raddr = ram_addr(i_rreg0, 0);
      end else if (rstate == R_T1) begin
        o_ren   = 1'b1;
        o_raddr = ram_addr(rreg1_q, 0);
      end else if (rstate == R_STREAM && rword < wpr - 1) begin
        if (rbeat == n - 2) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(rreg0_q, rword + 1);
        end else if (rbeat == n - 1) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(rreg1_q, rword + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rstate  <= R_IDLE;
      rreg0_q <= '0;
      rreg1_q <= '0;
      bcnt    <= '0;
      stage0  <= '0;
      sh0     <= '0;
      sh1     <= '0;
      reload  <= 1'b0;
      o_ready <= 1'b0;
    end else if (i_rreq) begin
      rstate  <= R_T1;
      rreg0_q <= i_rreg0;
      rreg1_q <= i_rreg1;
      reload  <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      case (rstate)
        R_T1: begin
          stage0  <= i_rdata;
          o_ready <= 1'b1;
          rstate  <= R_T2;
        end
        R_T2: begin
          sh0     <= stage0;
          sh1     <= i_rdata;
          bcnt    <= '0;
          reload  <= 1'b0;
          o_ready <= 1'b0;
          rstate  <= R_STREAM;
        end
        R_STREAM: begin
          sh0    <= src0 >> W;
          sh1    <= src1 >> W;
          bcnt   <= bcnt + 1'b1;
          reload <= (rbeat == n - 1) && (rword < wpr - 1);
          if (rbeat == n - 1) stage0 <= i_rdata;
          if (int'(bcnt) == beats - 1) rstate <= R_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qerv_rf_ram_if.sv
// Bench for qerv_rf_ram_if with W=1, width=8, csr_regs=4 against a qerv_rf_ram instance.
// Expected RAM writes and read beats are queued per cycle when driven and checked by a monitor.
module tb_qerv_rf_ram_if;
  import qerv_rf_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst, i_wreq, i_rreq;
  logic [5:0] i_wreg0, i_wreg1, i_rreg0, i_rreg1;
  logic       i_wen0, i_wen1;
  logic [0:0] i_wdata0, i_wdata1;
  logic       o_ready, o_wen, o_ren;
  logic [0:0] o_rdata0, o_rdata1;
  logic [7:0] o_waddr, o_wdata, o_raddr, ram_rdata;

  qerv_rf_ram_if #(.width(8), .W(1), .csr_regs(4)) dut (
    .clk(clk), .i_rst(i_rst), .i_wreq(i_wreq), .i_rreq(i_rreq), .o_ready(o_ready),
    .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_wen(o_wen), .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(ram_rdata)
  );

  qerv_rf_ram #(.width(8), .depth(144)) u_ram (
    .clk(clk), .waddr(o_waddr), .wdata(o_wdata), .wen(o_wen),
    .raddr(o_raddr), .ren(o_ren), .rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  wreg0, wreg1;
    logic        wen0, wen1;
    logic [31:0] d0, d1;
  } wvec_t;

  typedef struct {
    logic [5:0]  r0, r1;
    logic [31:0] e0, e1;
  } rvec_t;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wexp_t;

  typedef struct {
    int   cyc;
    logic d0, d1;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    rdyq[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      wexp_t we;
      rexp_t re;
      bit    exp_rdy;
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        we = wq.pop_front();
        checks++; errors++;
        $display("FAIL wr_missed: expected write addr %h data %h at cycle %0d", we.addr, we.data, we.cyc);
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        we = wq.pop_front();
        checks++;
        if (!(o_wen === 1'b1 && o_waddr === we.addr && o_wdata === we.data)) begin
          errors++;
          $display("FAIL wr_commit: got wen %b addr %h data %h expected addr %h data %h (cycle %0d)",
                   o_wen, o_waddr, o_wdata, we.addr, we.data, cyc);
        end
      end else if (o_wen !== 1'b0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got wen %b addr %h data %h with none expected (cycle %0d)",
                 o_wen, o_waddr, o_wdata, cyc);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        re = rq.pop_front();
        checks++;
        if (o_rdata0 !== re.d0 || o_rdata1 !== re.d1) begin
          errors++;
          $display("FAIL rd_beat: got %b/%b expected %b/%b (cycle %0d)", o_rdata0, o_rdata1, re.d0, re.d1, cyc);
        end
      end
      exp_rdy = (rdyq.size() > 0 && rdyq[0] == cyc);
      if (exp_rdy) void'(rdyq.pop_front());
      if (exp_rdy || o_ready !== 1'b0) begin
        checks++;
        if (o_ready !== exp_rdy) begin
          errors++;
          $display("FAIL rd_ready: got %b expected %b (cycle %0d)", o_ready, exp_rdy, cyc);
        end
      end
    end
  end

  // Entered and left #1 after a rising edge.
  task automatic wr(input wvec_t v, input bit use_wreq);
    wexp_t e;
    if (use_wreq) begin
      i_wreq = 1'b1;
      @(posedge clk); #1;
      i_wreq = 1'b0;
    end
    i_wreg0 = v.wreg0;
    i_wreg1 = v.wreg1;
    for (int j = 0; j < 32; j++) begin
      i_wen0 = v.wen0; i_wdata0 = v.d0[j];
      i_wen1 = v.wen1; i_wdata1 = v.d1[j];
      if (j % 8 == 7) begin
        if (v.wen0) begin
          e.cyc = cyc + 1; e.addr = {v.wreg0, 2'(j / 8)}; e.data = v.d0[8*(j/8) +: 8];
          wq.push_back(e);
        end
        if (v.wen1) begin
          e.cyc = cyc + 2; e.addr = {v.wreg1, 2'(j / 8)}; e.data = v.d1[8*(j/8) +: 8];
          wq.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    i_wen0 = 1'b0; i_wen1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Issues i_rreq in the current cycle; any stream still queued from here on is dropped.
  task automatic rd_issue(input logic [5:0] r0, input logic [5:0] r1,
                          input logic [31:0] e0, input logic [31:0] e1);
    rexp_t e;
    while (rq.size() > 0 && rq[$].cyc >= cyc) void'(rq.pop_back());
    i_rreq = 1'b1; i_rreg0 = r0; i_rreg1 = r1;
    rdyq.push_back(cyc + 2);
    for (int j = 0; j < 32; j++) begin
      e.cyc = cyc + 3 + j; e.d0 = e0[j]; e.d1 = e1[j];
      rq.push_back(e);
    end
    @(posedge clk); #1;
    i_rreq = 1'b0;
    i_rreg0 = 6'($urandom);
    i_rreg1 = 6'($urandom);
  endtask

  wvec_t wt[5];
  rvec_t rt[4];
  int    wen_seen;

  initial begin
    wt[0] = '{wreg0: 6'(MTVAL), wreg1: 6'(MEPC), wen0: 1'b1, wen1: 1'b1, d0: 32'hA5C30F69, d1: 32'h11223344};
    wt[1] = '{wreg0: 6'd5,      wreg1: 6'd0,     wen0: 1'b1, wen1: 1'b0, d0: 32'hDEADBEEF, d1: 32'h0};
    wt[2] = '{wreg0: 6'd7,      wreg1: 6'(MEPC), wen0: 1'b1, wen1: 1'b1, d0: 32'h12345678, d1: 32'hCAFEF00D};
    wt[3] = '{wreg0: 6'd0,      wreg1: 6'd0,     wen0: 1'b1, wen1: 1'b0, d0: 32'hFFFFFFFF, d1: 32'h0};
    wt[4] = '{wreg0: 6'd0,      wreg1: 6'(MTVEC), wen0: 1'b0, wen1: 1'b1, d0: 32'h0,       d1: 32'h80000100};

    rt[0] = '{r0: 6'd7,        r1: 6'(MEPC),  e0: 32'h12345678, e1: 32'hCAFEF00D};
    rt[1] = '{r0: 6'd0,        r1: 6'd5,      e0: 32'h00000000, e1: 32'hDEADBEEF};
    rt[2] = '{r0: 6'(MTVAL),   r1: 6'(MTVEC), e0: 32'hA5C30F69, e1: 32'h80000100};
    rt[3] = '{r0: 6'd5,        r1: 6'd0,      e0: 32'hDEADBEEF, e1: 32'h00000000};

    i_rst = 1'b1; i_wreq = 1'b0; i_rreq = 1'b0;
    i_wreg0 = '0; i_wreg1 = '0; i_wen0 = 1'b0; i_wen1 = 1'b0;
    i_wdata0 = '0; i_wdata1 = '0; i_rreg0 = '0; i_rreg1 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_wen",   32'(o_wen),   32'h0);
    chk("rst_ren",   32'(o_ren),   32'h0);
    chk("rst_waddr", 32'(o_waddr), 32'h0);
    chk("rst_wdata", 32'(o_wdata), 32'h0);
    chk("rst_raddr", 32'(o_raddr), 32'h0);
    chk("rst_rdata", {30'h0, o_rdata1, o_rdata0}, 32'h0);

    @(posedge clk); #1;
    i_rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) wr(wt[i], 1'b1);

    for (int i = 0; i < 4; i++) begin
      rd_issue(rt[i].r0, rt[i].r1, rt[i].e0, rt[i].e1);
      repeat (34) @(posedge clk);
      @(negedge clk);
      chk("rd_idle_zero", {30'h0, o_rdata1, o_rdata0}, 32'h0);
      @(posedge clk); #1;
    end

    // Stray beats followed by i_wreq: the next word must still start at beat 0.
    i_wreg0 = 6'd9;
    for (int j = 0; j < 3; j++) begin
      i_wen0 = 1'b1; i_wdata0 = 1'b1;
      @(posedge clk); #1;
    end
    i_wen0 = 1'b0;
    wr('{wreg0: 6'd9, wreg1: 6'd0, wen0: 1'b1, wen1: 1'b0, d0: 32'h600DCAFE, d1: 32'h0}, 1'b1);

    // Reset at beat 6 of word 0; the following write has no i_wreq.
    i_wreq = 1'b1;
    @(posedge clk); #1;
    i_wreq = 1'b0;
    i_wreg0 = 6'd9;
    for (int j = 0; j < 7; j++) begin
      i_wen0 = 1'b1; i_wdata0 = 1'(j);
      if (j == 6) i_rst = 1'b1;
      @(posedge clk); #1;
    end
    i_rst = 1'b0; i_wen0 = 1'b0;
    wen_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_wen) wen_seen++;
    end
    chk("rst_mid_write_no_wen", 32'(wen_seen), 32'h0);
    @(posedge clk); #1;
    wr('{wreg0: 6'd9, wreg1: 6'd0, wen0: 1'b1, wen1: 1'b0, d0: 32'h0BADF00D, d1: 32'h0}, 1'b0);
    rd_issue(6'd9, 6'd7, 32'h0BADF00D, 32'h12345678);
    repeat (35) @(posedge clk); #1;

    // Second i_rreq at beat 10 of a running stream.
    rd_issue(6'd7, 6'(MEPC), 32'h12345678, 32'hCAFEF00D);
    repeat (12) @(posedge clk); #1;
    rd_issue(6'd5, 6'(MTVAL), 32'hDEADBEEF, 32'hA5C30F69);
    repeat (34) @(posedge clk);
    @(negedge clk);
    chk("restart_idle_zero", {30'h0, o_rdata1, o_rdata0}, 32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wq_drained",   32'(wq.size()),   32'h0);
    chk("rq_drained",   32'(rq.size()),   32'h0);
    chk("rdyq_drained", 32'(rdyq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
